// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default frame geometry and
// counter widths used by both the transmitter and the future receiver.
package uart_pkg;

    localparam int UART_OSR       = 16;
    localparam int UART_DATA_BITS = 8;

    localparam int TICK_W = $clog2(UART_OSR);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter paced by an external 16x baud strobe.
// One byte in flight; writes while busy are dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OSR       = UART_OSR,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 brg_stb_i,
    input  logic                 we_i,
    input  logic [DATA_BITS-1:0] din_i,
    output logic                 dout_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_e          state, state_n;
    logic [TW-1:0]        tick, tick_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 dout_n, busy_n;
    logic                 tick_done;

    assign tick_done = brg_stb_i && (tick == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            dout_o  <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            dout_o  <= dout_n;
            busy_o  <= busy_n;
        end
    end

    // Outputs are computed for the state being entered, so the registered
    // line and busy flag change on the same edge as the state.
    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        dout_n    = 1'b1;
        busy_n    = 1'b0;

        if (state != IDLE && brg_stb_i) begin
            tick_n = tick_done ? '0 : tick + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (we_i) begin
                    shreg_n   = din_i;
                    tick_n    = '0;
                    bit_cnt_n = '0;
                    state_n   = START;
                    dout_n    = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                busy_n = 1'b1;
                dout_n = 1'b0;
                if (tick_done) begin
                    state_n = DATA;
                    dout_n  = shreg[0];
                end
            end
            DATA: begin
                busy_n = 1'b1;
                dout_n = shreg[0];
                if (tick_done) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = STOP;
                        dout_n  = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        dout_n    = shreg_n[0];
                    end
                end
            end
            STOP: begin
                busy_n = 1'b1;
                if (tick_done) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a strobe-counting frame model predicts the
// line and busy flag every clock.
module tb_uart_tx;

    localparam int OSR   = 16;
    localparam int NB    = 8;
    localparam int FRAME = OSR * (NB + 2);
    localparam int LIMIT = 4000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       brg_stb_i = 1'b0;
    logic       we_i = 1'b0;
    logic [7:0] din_i = 8'h00;
    logic       dout_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    int per = 4;
    int ph = 0;
    bit rnd_stb = 1'b0;
    bit mon_en = 1'b0;

    // Model: a frame is FRAME strobes long once accepted; bit i of the
    // frame covers strobe counts [16*i, 16*i+15].
    bit         m_act = 1'b0;
    int         m_k = 0;
    logic [7:0] m_byte = 8'h00;

    uart_tx dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .brg_stb_i (brg_stb_i),
        .we_i      (we_i),
        .din_i     (din_i),
        .dout_o    (dout_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_act <= 1'b0;
            m_k   <= 0;
        end else if (m_act) begin
            if (brg_stb_i) begin
                m_k <= m_k + 1;
                if (m_k + 1 == FRAME) m_act <= 1'b0;
            end
        end else if (we_i) begin
            m_act  <= 1'b1;
            m_k    <= 0;
            m_byte <= din_i;
        end
    end

    function automatic logic exp_line();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_k / OSR;
        if (idx == 0) return 1'b0;
        if (idx <= NB) return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("line", 32'(dout_o), 32'(exp_line()));
            chk("busy", 32'(busy_o), 32'(m_act));
        end
    end

    task automatic step(input logic we, input logic [7:0] d);
        @(negedge clk_i);
        we_i  = we;
        din_i = d;
        if (rnd_stb) begin
            brg_stb_i = ($urandom_range(2) == 0);
        end else begin
            brg_stb_i = (ph == 0);
            ph = (ph + 1) % per;
        end
    endtask

    task automatic wait_idle(input int wr_pct);
        int n = 0;
        do begin
            step($urandom_range(99) < wr_pct, 8'($urandom));
            n++;
        end while ((m_act || busy_o) && n < LIMIT);
        chk("frame_end", 32'(m_act | busy_o), 32'd0);
    endtask

    task automatic run_to(input int k);
        int n = 0;
        while (m_k < k && n < LIMIT) begin
            step(1'b0, 8'($urandom));
            n++;
        end
        chk("reach_tick", 32'(m_k >= k), 32'd1);
    endtask

    initial begin
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        chk("rst_line", 32'(dout_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // strobes every clock while idle must not disturb the line
        per = 1;
        ph  = 0;
        repeat (20) step(1'b0, 8'($urandom));

        // reference frames, strobe every 4th clock, back-to-back
        per = 4;
        step(1'b1, 8'h75);
        wait_idle(0);
        step(1'b1, 8'h53);
        wait_idle(0);

        // writes while busy are dropped
        step(1'b1, 8'h75);
        run_to(50);
        step(1'b1, 8'hFF);
        run_to(90);
        step(1'b1, 8'hFF);
        wait_idle(0);
        repeat (3) step(1'b0, 8'($urandom));

        // reset during data bit 3
        step(1'b1, 8'($urandom));
        run_to(OSR * 4 + 8);
        step(1'b0, 8'h00);
        rst_i = 1'b1;
        step(1'b0, 8'h00);
        rst_i = 1'b0;
        chk("rst_mid_line", 32'(dout_o), 32'd1);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        step(1'b1, 8'hA5);
        wait_idle(0);

        // strobe phase sweep relative to the accepting edge
        for (int off = 0; off < 4; off++) begin
            ph = off;
            step(1'b1, 8'($urandom));
            wait_idle(0);
        end

        // we_i held high: the terminal stop strobe cycle must not accept
        step(1'b1, 8'h3C);
        run_to(100);
        for (int n = 0; n < LIMIT && m_act; n++) step(1'b1, 8'($urandom));
        wait_idle(0);

        // random byte, random strobe period, stray writes while busy
        for (int i = 0; i < 6; i++) begin
            per = $urandom_range(5, 1);
            ph  = $urandom_range(per - 1);
            step(1'b1, 8'($urandom));
            wait_idle(3);
        end

        // irregular strobe spacing
        rnd_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'($urandom));
            wait_idle(2);
        end
        repeat (4) step(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
